// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA descriptor sequencer.
// Descriptor word indices, error codes and FSM state encodings.
package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LAUNCH,
    ST_XFER_WAIT,
    ST_NEXT,
    ST_FINISH
  } dma_state_e;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_REQ,
    FS_WAIT
  } fetch_state_e;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_ALIGN    = 3'd1;
  localparam logic [2:0] ERR_XFER     = 3'd2;
  localparam logic [2:0] ERR_ABORT    = 3'd3;
  localparam logic [2:0] ERR_OVERFLOW = 3'd4;

  // Word index within a descriptor; byte offset is index * 4.
  localparam logic [1:0] W_SRC  = 2'd0;
  localparam logic [1:0] W_DST  = 2'd1;
  localparam logic [1:0] W_LEN  = 2'd2;
  localparam logic [1:0] W_NEXT = 2'd3;

  localparam int LEN_W      = 24;
  localparam int IRQ_EN_BIT = 31;

  function automatic logic [2:0] first_err(
    input logic [2:0] cur,
    input logic [2:0] nw
  );
    return (cur == ERR_NONE) ? nw : cur;
  endfunction

endpackage

// File: rtl/dma_desc_fetch.sv
// Descriptor read master: four word reads, at most one outstanding.
// Pulses desc_valid_o when the next-pointer word is captured.
import dma_pkg::*;

module dma_desc_fetch #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] ptr_i,
  input  logic              stop_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_wait_rq_i,
  input  logic [31:0]       mem_rd_data_i,
  input  logic              mem_rd_valid_i,
  output logic              desc_valid_o,
  output logic              abort_o,
  output logic [ADDR_W-1:0] src_o,
  output logic [ADDR_W-1:0] dst_o,
  output logic [LEN_W-1:0]  len_o,
  output logic [ADDR_W-1:0] next_o
);

  fetch_state_e      st_q, st_d;
  logic [1:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] next_q, next_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] word;

  assign word = ADDR_W'(mem_rd_data_i);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q   <= FS_IDLE;
      idx_q  <= '0;
      ptr_q  <= '0;
      src_q  <= '0;
      dst_q  <= '0;
      next_q <= '0;
      len_q  <= '0;
    end else begin
      st_q   <= st_d;
      idx_q  <= idx_d;
      ptr_q  <= ptr_d;
      src_q  <= src_d;
      dst_q  <= dst_d;
      next_q <= next_d;
      len_q  <= len_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    idx_d  = idx_q;
    ptr_d  = ptr_q;
    src_d  = src_q;
    dst_d  = dst_q;
    next_d = next_q;
    len_d  = len_q;
    unique case (st_q)
      FS_IDLE: begin
        if (start_i) begin
          st_d  = FS_REQ;
          ptr_d = ptr_i;
          idx_d = '0;
        end
      end
      FS_REQ: begin
        // A stop is only honoured before the read is accepted.
        if (stop_i) st_d = FS_IDLE;
        else if (!mem_wait_rq_i) st_d = FS_WAIT;
      end
      FS_WAIT: begin
        if (mem_rd_valid_i) begin
          unique case (idx_q)
            W_SRC:   src_d  = word;
            W_DST:   dst_d  = word;
            W_LEN:   len_d  = mem_rd_data_i[LEN_W-1:0];
            default: next_d = word;
          endcase
          if (idx_q == W_NEXT) begin
            st_d = FS_IDLE;
          end else begin
            idx_d = idx_q + 2'd1;
            st_d  = FS_REQ;
          end
        end
      end
      default: st_d = FS_IDLE;
    endcase
  end

  always_comb begin
    mem_rd_o     = (st_q == FS_REQ) && !stop_i;
    abort_o      = (st_q == FS_REQ) && stop_i;
    desc_valid_o = (st_q == FS_WAIT) && mem_rd_valid_i
                   && (idx_q == W_NEXT);
    mem_addr_o   = ptr_q + ADDR_W'({idx_q, 2'b00});
  end

  assign src_o  = src_q;
  assign dst_o  = dst_q;
  assign len_o  = len_q;
  assign next_o = next_q;

endmodule

// File: rtl/dma_desc_sequencer.sv
// Walks a descriptor chain, launching one transfer per descriptor.
// Reports busy/done/error/count and a completion interrupt pulse.
import dma_pkg::*;

module dma_desc_sequencer #(
  parameter int MAX_DESC = 256,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go_i,
  input  logic              stop_i,
  input  logic [ADDR_W-1:0] desc_ptr_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_wait_rq_i,
  input  logic [31:0]       mem_rd_data_i,
  input  logic              mem_rd_valid_i,
  output logic              xfer_start_o,
  output logic [ADDR_W-1:0] xfer_src_o,
  output logic [ADDR_W-1:0] xfer_dst_o,
  output logic [23:0]       xfer_len_o,
  input  logic              xfer_done_i,
  input  logic              xfer_err_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [2:0]        err_code_o,
  output logic [15:0]       desc_count_o,
  output logic              irq_o
);

  dma_state_e        st_q, st_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              irq_q, irq_d;
  logic [2:0]        err_q, err_d;
  logic [15:0]       cnt_q, cnt_d, cnt_inc;
  logic              fetch_start, desc_valid, fetch_abort;
  logic [ADDR_W-1:0] fetch_ptr, src, dst, nxt;
  logic [LEN_W-1:0]  len;

  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  dma_desc_fetch #(.ADDR_W(ADDR_W)) u_fetch (
    .clk            (clk),
    .reset          (reset),
    .start_i        (fetch_start),
    .ptr_i          (fetch_ptr),
    .stop_i         (stop_i),
    .mem_rd_o       (mem_rd_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wait_rq_i  (mem_wait_rq_i),
    .mem_rd_data_i  (mem_rd_data_i),
    .mem_rd_valid_i (mem_rd_valid_i),
    .desc_valid_o   (desc_valid),
    .abort_o        (fetch_abort),
    .src_o          (src),
    .dst_o          (dst),
    .len_o          (len),
    .next_o         (nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q   <= ST_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      irq_q  <= 1'b0;
      err_q  <= ERR_NONE;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_d;
      busy_q <= busy_d;
      done_q <= done_d;
      irq_q  <= irq_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    busy_d = busy_q;
    done_d = done_q;
    irq_d  = 1'b0;
    err_d  = err_q;
    cnt_d  = cnt_q;
    unique case (st_q)
      ST_IDLE: begin
        if (go_i) begin
          cnt_d = '0;
          if (desc_ptr_i[3:0] == 4'd0) begin
            st_d   = ST_FETCH;
            busy_d = 1'b1;
            done_d = 1'b0;
            err_d  = ERR_NONE;
          end else begin
            err_d  = ERR_ALIGN;
            done_d = 1'b1;
            irq_d  = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        if (fetch_abort) begin
          err_d = first_err(err_q, ERR_ABORT);
          st_d  = ST_FINISH;
        end else if (desc_valid) begin
          st_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        st_d = (len != '0) ? ST_XFER_WAIT : ST_NEXT;
      end
      ST_XFER_WAIT: begin
        if (xfer_done_i) begin
          if (xfer_err_i) begin
            err_d = first_err(err_q, ERR_XFER);
            st_d  = ST_FINISH;
          end else begin
            st_d = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        cnt_d = cnt_inc;
        st_d  = ST_FINISH;
        if (stop_i) begin
          err_d = first_err(err_q, ERR_ABORT);
        end else if (nxt == '0) begin
          st_d = ST_FINISH;
        end else if (nxt[3:0] != 4'd0) begin
          err_d = first_err(err_q, ERR_ALIGN);
        end else if ({16'd0, cnt_inc} >= 32'(MAX_DESC)) begin
          err_d = first_err(err_q, ERR_OVERFLOW);
        end else begin
          st_d = ST_FETCH;
        end
      end
      ST_FINISH: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        irq_d  = 1'b1;
        st_d   = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fetch_start  = (st_d == ST_FETCH) && (st_q != ST_FETCH);
    fetch_ptr    = (st_q == ST_IDLE) ? desc_ptr_i : nxt;
    xfer_start_o = (st_q == ST_LAUNCH) && (len != '0);
  end

  assign xfer_src_o   = src;
  assign xfer_dst_o   = dst;
  assign xfer_len_o   = len;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_code_o   = err_q;
  assign desc_count_o = cnt_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_dma_desc_sequencer.sv
// Bench for dma_desc_sequencer: memory and transfer-engine responders,
// scoreboard queues for reads and launches, table of chain scenarios.
import dma_pkg::*;

module tb_dma_desc_sequencer;

  localparam int TB_MAX = 4;

  logic        clk, reset, go_i, stop_i;
  logic [31:0] desc_ptr_i;
  logic        mem_rd_o;
  logic [31:0] mem_addr_o;
  logic        mem_wait_rq_i;
  logic [31:0] mem_rd_data_i;
  logic        mem_rd_valid_i;
  logic        xfer_start_o;
  logic [31:0] xfer_src_o, xfer_dst_o;
  logic [23:0] xfer_len_o;
  logic        xfer_done_i, xfer_err_i;
  logic        busy_o, done_o, irq_o;
  logic [2:0]  err_code_o;
  logic [15:0] desc_count_o;

  dma_desc_sequencer #(.MAX_DESC(TB_MAX), .ADDR_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .go_i           (go_i),
    .stop_i         (stop_i),
    .desc_ptr_i     (desc_ptr_i),
    .mem_rd_o       (mem_rd_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wait_rq_i  (mem_wait_rq_i),
    .mem_rd_data_i  (mem_rd_data_i),
    .mem_rd_valid_i (mem_rd_valid_i),
    .xfer_start_o   (xfer_start_o),
    .xfer_src_o     (xfer_src_o),
    .xfer_dst_o     (xfer_dst_o),
    .xfer_len_o     (xfer_len_o),
    .xfer_done_i    (xfer_done_i),
    .xfer_err_i     (xfer_err_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_code_o     (err_code_o),
    .desc_count_o   (desc_count_o),
    .irq_o          (irq_o)
  );

  typedef struct {
    string       name;
    logic [31:0] ptr;
    int          wait_n;
    int          xfail;
    logic [2:0]  err;
    int          cnt;
    int          starts;
    int          lat;
  } vec_t;

  vec_t        vecs[7];
  logic [31:0] mem[logic [31:0]];
  logic [31:0] rdq[$];
  logic [87:0] xq[$];
  logic [87:0] xexp;
  logic [31:0] pend_addr, stall_addr;
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, starts = 0, irqs = 0, start_cyc = 0, go_cyc = 0;
  int wait_n = 0, stall_cnt = 0, xcnt = 0, xfail_arm = 0;
  bit pend = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [159:0] act,
                       input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input logic [31:0] val);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0h want nothing", nm, val);
  endtask

  // Memory and transfer engine, driven away from the active edge.
  always @(negedge clk) begin
    mem_rd_valid_i = 1'b0;
    xfer_done_i    = 1'b0;
    xfer_err_i     = 1'b0;
    if (reset) begin
      pend          = 0;
      stall_cnt     = 0;
      xcnt          = 0;
      mem_wait_rq_i = 1'b0;
    end else begin
      if (pend) begin
        mem_rd_valid_i = 1'b1;
        mem_rd_data_i  = mem[pend_addr];
        pend           = 0;
      end
      if (mem_rd_o) begin
        if (stall_cnt == 0) stall_addr = mem_addr_o;
        else check("stall_addr", 160'(mem_addr_o), 160'(stall_addr));
        if (stall_cnt < wait_n) begin
          mem_wait_rq_i = 1'b1;
          stall_cnt++;
        end else begin
          mem_wait_rq_i = 1'b0;
          stall_cnt     = 0;
          pend          = 1;
          pend_addr     = mem_addr_o;
          if (rdq.size() == 0) fail_now("rd_extra", mem_addr_o);
          else check("rd_addr", 160'(mem_addr_o), 160'(rdq.pop_front()));
        end
      end else begin
        mem_wait_rq_i = 1'b0;
      end
      if (xcnt > 0) begin
        xcnt--;
        if (xcnt == 0) begin
          xfer_done_i = 1'b1;
          xfer_err_i  = (xfail_arm != 0);
          xfail_arm   = 0;
          check("xfer_hold", 160'({xfer_src_o, xfer_dst_o, xfer_len_o}),
                160'(xexp));
        end
      end
      if (xfer_start_o) begin
        if (starts == 0) start_cyc = cyc;
        starts++;
        xcnt = 3;
        if (xq.size() == 0) begin
          fail_now("xfer_extra", xfer_src_o);
        end else begin
          xexp = xq.pop_front();
          check("xfer_args", 160'({xfer_src_o, xfer_dst_o, xfer_len_o}),
                160'(xexp));
        end
      end
      if (irq_o) irqs++;
    end
  end

  task automatic put_desc(input logic [31:0] a, input logic [31:0] s,
                          input logic [31:0] d, input logic [31:0] l,
                          input logic [31:0] n);
    mem[a]      = s;
    mem[a + 4]  = d;
    mem[a + 8]  = l;
    mem[a + 12] = n;
  endtask

  // Reference walk of the chain in bench memory.
  task automatic push_expect(input logic [31:0] ptr, input int xfail);
    logic [31:0] p = ptr;
    logic [31:0] nx, wl;
    logic [23:0] ln;
    int n = 0;
    if (p[3:0] != 4'd0) return;
    forever begin
      for (int w = 0; w < 4; w++) rdq.push_back(p + 32'(4 * w));
      wl = mem[p + 8];
      ln = wl[23:0];
      if (ln != 0) xq.push_back({mem[p], mem[p + 4], ln});
      if (ln != 0 && xfail != 0 && n == 0) break;
      n++;
      nx = mem[p + 12];
      if (nx == 0 || nx[3:0] != 4'd0 || n >= TB_MAX) break;
      p = nx;
    end
  endtask

  task automatic pulse_go(input logic [31:0] ptr);
    @(posedge clk); #1;
    go_i       = 1'b1;
    desc_ptr_i = ptr;
    go_cyc     = cyc;
    @(posedge clk); #1;
    go_i = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (k < 3000 && !(done_o && !busy_o)) begin
      @(posedge clk); #1;
      k++;
    end
    if (k == 3000) fail_now({nm, "_timeout"}, 32'(k));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    starts    = 0;
    irqs      = 0;
    wait_n    = v.wait_n;
    xfail_arm = v.xfail;
    push_expect(v.ptr, v.xfail);
    pulse_go(v.ptr);
    wait_done(v.name);
    check({v.name, "_err"}, 160'(err_code_o), 160'(v.err));
    check({v.name, "_cnt"}, 160'(desc_count_o), 160'(v.cnt));
    check({v.name, "_done"}, 160'({done_o, busy_o}), 160'(2'b10));
    check({v.name, "_starts"}, 160'(starts), 160'(v.starts));
    check({v.name, "_irqs"}, 160'(irqs), 160'(1));
    check({v.name, "_rdq"}, 160'(rdq.size()), 160'(0));
    check({v.name, "_xq"}, 160'(xq.size()), 160'(0));
    if (v.lat != 0)
      check({v.name, "_lat"}, 160'(start_cyc - go_cyc - 1), 160'(v.lat));
    rdq.delete();
    xq.delete();
  endtask

  initial begin
    int k;
    reset         = 1'b1;
    go_i          = 1'b0;
    stop_i        = 1'b0;
    desc_ptr_i    = '0;
    mem_wait_rq_i = 1'b0;
    mem_rd_data_i = '0;
    mem_rd_valid_i = 1'b0;
    xfer_done_i   = 1'b0;
    xfer_err_i    = 1'b0;

    put_desc(32'h100, 32'h1000, 32'h2000, 32'd64, 32'h0);
    put_desc(32'h200, 32'h3000, 32'h4000, 32'd16, 32'h300);
    put_desc(32'h300, 32'h3100, 32'h4100, 32'd32, 32'h400);
    put_desc(32'h400, 32'h3200, 32'h4200, 32'd48, 32'h0);
    put_desc(32'h500, 32'h5000, 32'h5100, 32'd8, 32'h206);
    put_desc(32'h600, 32'h6000, 32'h6100, 32'd100, 32'h700);
    put_desc(32'h700, 32'h7000, 32'h7100, 32'd200, 32'h0);
    put_desc(32'h800, 32'h8000, 32'h8100, 32'd1 << IRQ_EN_BIT, 32'h900);
    put_desc(32'h900, 32'h9000, 32'h9100, 32'd32, 32'h0);
    put_desc(32'hA00, 32'hA000, 32'hA100, 32'd4, 32'hA00);

    vecs[0] = '{"single",   32'h100, 0, 0, 3'd0, 1, 1, 8};
    vecs[1] = '{"chain3",   32'h200, 2, 0, 3'd0, 3, 3, 0};
    vecs[2] = '{"bad_ptr",  32'h104, 0, 0, 3'd1, 0, 0, 0};
    vecs[3] = '{"bad_next", 32'h500, 0, 0, 3'd1, 1, 1, 0};
    vecs[4] = '{"xfer_err", 32'h600, 0, 1, 3'd2, 0, 1, 0};
    vecs[5] = '{"zero_len", 32'h800, 0, 0, 3'd0, 2, 1, 0};
    vecs[6] = '{"overflow", 32'hA00, 1, 0, 3'd4, 4, 4, 0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_outs",
          160'({mem_rd_o, mem_addr_o, xfer_start_o, xfer_src_o,
                xfer_dst_o, xfer_len_o, busy_o, done_o, err_code_o,
                desc_count_o, irq_o}), '0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Stop during a transfer, plus a go that must be ignored.
    starts = 0;
    irqs   = 0;
    wait_n = 0;
    for (int w = 0; w < 4; w++) rdq.push_back(32'h600 + 32'(4 * w));
    xq.push_back({32'h6000, 32'h6100, 24'd100});
    pulse_go(32'h600);
    k = 0;
    while (k < 500 && starts == 0) begin
      @(posedge clk); #1;
      k++;
    end
    if (k == 500) fail_now("stop_launch_timeout", 32'(k));
    go_i       = 1'b1;
    desc_ptr_i = 32'h100;
    stop_i     = 1'b1;
    @(posedge clk); #1;
    go_i = 1'b0;
    wait_done("stop");
    stop_i = 1'b0;
    check("stop_err", 160'(err_code_o), 160'(ERR_ABORT));
    check("stop_cnt", 160'(desc_count_o), 160'(1));
    check("stop_starts", 160'(starts), 160'(1));
    check("stop_irqs", 160'(irqs), 160'(1));
    check("stop_rdq", 160'(rdq.size()), 160'(0));
    rdq.delete();
    xq.delete();

    // Asynchronous reset with a read in flight, then a clean restart.
    starts = 0;
    irqs   = 0;
    push_expect(32'h100, 0);
    pulse_go(32'h100);
    k = 0;
    while (k < 500 && !pend) begin
      @(posedge clk); #1;
      k++;
    end
    if (k == 500) fail_now("rst_inflight_timeout", 32'(k));
    reset = 1'b1;
    #1;
    check("rst_mid_outs",
          160'({mem_rd_o, mem_addr_o, xfer_start_o, xfer_src_o,
                xfer_dst_o, xfer_len_o, busy_o, done_o, err_code_o,
                desc_count_o, irq_o}), '0);
    rdq.delete();
    xq.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_no_irq", 160'(irqs), 160'(0));
    reset = 1'b0;
    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
